// File: rtl/strait_pkg.sv
// Shared definitions for the accumulator readout path: the readout FSM
// state encoding, default array geometry and a lane-offset helper used to
// slice the flattened partial-sum buses.
package strait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } readout_state_t;

    localparam int DEF_SYSTOLIC_SIZE     = 8;
    localparam int DEF_PARTIAL_SUM_WIDTH = 19;

    // Bit position of the LSB of a lane inside a flattened row; lane 0 sits
    // in the least significant bits.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry FIFO carrying {row, data} words between the accumulator read
// pipeline and the valid/ready output port. The head entry drives the output
// directly, so it stays stable while the consumer stalls. A flush empties the
// FIFO in one cycle and takes priority over push and pop.
module readout_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy update on push/pop, cleared by flush.
    // NOTE: the storage is reset as well because the head entry is the
    // module's data output, which must read zero out of reset; a flush only
    // moves the pointers and leaves stale contents behind invalid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/accumulator_readout.sv
// Host-side reader for the accumulator result memory. A start pulse walks the
// accumulator read address over every row, captures each returned row into a
// 2-entry FIFO and streams the rows out on a valid/ready port. Reads are only
// issued while a FIFO slot is guaranteed, so backpressure never loses data.
// test_mode aborts a run and blocks new ones.
// Optional build macro READOUT_RELU_EN: clamp negative lanes to zero as rows
// are written into the FIFO.
module accumulator_readout
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = DEF_SYSTOLIC_SIZE,
    parameter int PARTIAL_SUM_WIDTH = DEF_PARTIAL_SUM_WIDTH,
    parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       test_mode,
    output logic [ADDR_WIDTH-1:0]                      rd_addr,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_flat,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data_flat,
    output logic [ADDR_WIDTH-1:0]                      out_row,
    output logic                                       busy,
    output logic                                       done
);

    localparam int                    DATA_W   = SYSTOLIC_SIZE * PARTIAL_SUM_WIDTH;
    localparam int                    ENTRY_W  = ADDR_WIDTH + DATA_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    readout_state_t        r_state;
    readout_state_t        w_state_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_row;

    logic                  w_issue;
    logic                  w_flush;
    logic                  w_done;
    logic                  w_launch;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic [2:0]            w_credit_used;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_valid;
    logic [ENTRY_W-1:0]    w_fifo_out;
    logic [DATA_W-1:0]     w_push_data;

    // A row leaves on every handshake with the consumer.
    assign w_pop = w_fifo_valid && out_ready;

    // Slots already spoken for: rows held, plus the read returning next
    // cycle, less the row leaving this cycle. A read is issued only while
    // that leaves a free slot for it.
    assign w_credit_used = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit_ok   = (w_credit_used < 3'd2);

    // Readout state register.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus issue, flush and done strobes.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_flush      = 1'b0;
        w_done       = 1'b0;
        w_launch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !test_mode) begin
                    w_launch     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (test_mode) begin
                    w_flush      = 1'b1;
                    w_state_next = IDLE;
                end else if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_rd_addr == LAST_ROW) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (test_mode) begin
                    w_flush      = 1'b1;
                    w_state_next = IDLE;
                end else if (w_pop && (w_fifo_out[ENTRY_W-1 -: ADDR_WIDTH] == LAST_ROW)) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read address walk and the one-cycle read-in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr      <= '0;
            r_inflight     <= 1'b0;
            r_inflight_row <= '0;
        end else begin
            if (w_launch) begin
                r_rd_addr <= '0;
            end else if (w_issue && (r_rd_addr != LAST_ROW)) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_row <= r_rd_addr;
            end
        end
    end

    // Per-lane write data: optionally clamp negative partial sums to zero.
    for (genvar lane = 0; lane < SYSTOLIC_SIZE; lane++) begin : g_lane
        logic [PARTIAL_SUM_WIDTH-1:0] w_lane;
        assign w_lane = partial_sum_in_flat[lane_lsb(lane, PARTIAL_SUM_WIDTH) +: PARTIAL_SUM_WIDTH];
`ifdef READOUT_RELU_EN
        assign w_push_data[lane_lsb(lane, PARTIAL_SUM_WIDTH) +: PARTIAL_SUM_WIDTH] =
            w_lane[PARTIAL_SUM_WIDTH-1] ? '0 : w_lane;
`else
        assign w_push_data[lane_lsb(lane, PARTIAL_SUM_WIDTH) +: PARTIAL_SUM_WIDTH] = w_lane;
`endif
    end

    readout_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_row, w_push_data}),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_out),
        .o_count     (w_fifo_count)
    );

    assign rd_addr       = r_rd_addr;
    assign out_valid     = w_fifo_valid;
    assign out_row       = w_fifo_out[ENTRY_W-1 -: ADDR_WIDTH];
    assign out_data_flat = w_fifo_out[DATA_W-1:0];
    assign busy          = (r_state != IDLE);
    assign done          = w_done;

endmodule

// File: tb/tb_accumulator_readout.sv
// Self-checking bench for accumulator_readout: cycle table for a full
// readout, scoreboard of expected rows, and directed backpressure, restart,
// abort, sign-handling and reset sequences.
module tb_accumulator_readout;

    localparam int N   = 8;
    localparam int PSW = 19;
    localparam int AW  = 3;
    localparam int DW  = N * PSW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          test_mode = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] out_row;
    logic [DW-1:0] psum = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    bit neg_mode = 1'b0;

    logic [AW+DW-1:0] sb_q[$];
    logic [AW+DW-1:0] held;
    bit               held_v = 1'b0;

    typedef struct {
        logic          busy;
        logic          valid;
        logic          done;
        logic [AW-1:0] row;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t vecs[11];

    accumulator_readout dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .test_mode           (test_mode),
        .rd_addr             (rd_addr),
        .partial_sum_in_flat (psum),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data_flat       (out_data),
        .out_row             (out_row),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Raw accumulator contents (before any clamping in the reader).
    function automatic logic [DW-1:0] raw_row(input int r);
        logic [DW-1:0] d;
        int v;
        d = '0;
        for (int c = 0; c < N; c++) begin
            v = neg_mode ? ((c % 2 == 1) ? 7 : -5) : (r * 16 + c);
            d[c*PSW +: PSW] = PSW'(v);
        end
        return d;
    endfunction

    // Expected payload for one row as the consumer should see it.
    function automatic logic [DW-1:0] exp_row(input int r);
        logic [DW-1:0] d;
        d = raw_row(r);
`ifdef READOUT_RELU_EN
        for (int c = 0; c < N; c++) begin
            if (d[c*PSW + PSW - 1]) d[c*PSW +: PSW] = '0;
        end
`endif
        return d;
    endfunction

    // Accumulator model: synchronous read with one cycle of latency.
    always @(posedge clk) psum <= raw_row(int'(rd_addr));

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on handshake, stall stability, done count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v && out_valid) check("hold_stable", {out_row, out_data}, held);
            held_v = out_valid && !out_ready;
            held   = {out_row, out_data};
            if (done) done_count++;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got row %0d, expected no row", out_row);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = sb_q.pop_front();
                    check("row_index", out_row, e[AW+DW-1 -: AW]);
                    check("row_data", out_data, e[DW-1:0]);
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // Pulse start for one edge and queue the rows the run must deliver.
    task automatic pulse_start();
        start = 1'b1;
        for (int r = 0; r < N; r++) sb_q.push_back({AW'(r), exp_row(r)});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int base;
        int i;
        base = done_count;
        i = 0;
        while (done_count == base && i < budget) begin
            tick();
            i++;
        end
        tick();
        check(name, done_count - base, 1);
    endtask

    initial begin
        int peak;
        int base;

        // Expected per-cycle view of one readout with out_ready held high,
        // starting in the first cycle after the start edge.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd2};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd1, 3'd3};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'd2, 3'd4};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd4, 3'd6};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd5, 3'd7};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd6, 3'd7};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd7, 3'd7};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd7};

        // Reset state.
        repeat (3) tick();
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Full readout, cycle-exact.
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t%0d_busy", i + 1), busy, vecs[i].busy);
            check($sformatf("t%0d_valid", i + 1), out_valid, vecs[i].valid);
            check($sformatf("t%0d_done", i + 1), done, vecs[i].done);
            check($sformatf("t%0d_rd_addr", i + 1), rd_addr, vecs[i].addr);
            if (vecs[i].valid) check($sformatf("t%0d_row", i + 1), out_row, vecs[i].row);
            tick();
        end
        check("run1_done_count", done_count, 1);
        check("run1_rows_left", sb_q.size(), 0);

        // Backpressure: out_ready low for five cycles after row 2.
        tick();
        pulse_start();
        repeat (4) tick();
        check("bp_row2_visible", {out_valid, out_row}, {1'b1, 3'd2});
        tick();
        out_ready = 1'b0;
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            if (int'(dut.u_fifo.o_count) > peak) peak = int'(dut.u_fifo.o_count);
            check("bp_stall_valid", out_valid, 1);
            check("bp_stall_row", out_row, 3);
            check("bp_stall_rd_addr", rd_addr, 5);
            tick();
        end
        check("bp_fifo_peak", peak, 2);
        out_ready = 1'b1;
        wait_done(40, "bp_one_done");
        check("bp_rows_left", sb_q.size(), 0);

        // start while busy is ignored.
        tick();
        pulse_start();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, "restart_one_done");
        base = done_count;
        repeat (12) tick();
        check("restart_no_second_run", {busy, 32'(done_count - base)}, 0);
        check("restart_rows_left", sb_q.size(), 0);

        // Abort by test_mode during row 4.
        base = done_count;
        pulse_start();
        repeat (6) tick();
        check("abort_row4_visible", {out_valid, out_row}, {1'b1, 3'd4});
        test_mode = 1'b1;
        tick();
        check("abort_valid_low", out_valid, 0);
        check("abort_busy_low", busy, 0);
        sb_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_in_test_mode_ignored", busy, 0);
        check("abort_no_done", done_count - base, 0);
        test_mode = 1'b0;
        tick();
        pulse_start();
        wait_done(40, "after_abort_done");
        check("after_abort_rows_left", sb_q.size(), 0);

        // Sign handling of lanes: -5 and +7.
        neg_mode = 1'b1;
        tick();
        pulse_start();
        repeat (2) tick();
`ifdef READOUT_RELU_EN
        check("lane_neg5", out_data[PSW-1:0], 0);
`else
        check("lane_neg5", out_data[PSW-1:0], 19'h7FFFB);
`endif
        check("lane_pos7", out_data[2*PSW-1:PSW], 7);
        wait_done(40, "sign_done");
        neg_mode = 1'b0;

        // Asynchronous reset in the middle of a run.
        tick();
        pulse_start();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_rd_addr", rd_addr, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_row", out_row, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", {busy, out_valid, rd_addr}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
